formula_evaluator: RTL and testbench
====================================

// Module: formula_evaluator
// PURPOSE
//  Consumes the `formula` struct from the clause loader, plus a partial variable
//  assignment, and evaluates it clause by clause, one literal per cycle.
//  Reports SAT / CONFLICT / UNRESOLVED and the lowest-index unit clause.
//  Forms the evaluation/unit-detection stage feeding the DPLL search controller.
//  Uses the common package: formula type, number_literal, number_clauses, width_clausearray, width_litarray.
// PARAMETERS
//  STOP_ON_CONFLICT  1  1: finish at the first conflicting clause; 0: scan all clauses
// PORTS
//  clock         in   1                      single clock, rising edge
//  reset         in   1                      synchronous, active-high
//  start         in   1                      request evaluation; sampled only in IDLE
//  formula_in    in   formula                formula to evaluate; snapshotted on accepted start
//  assign_val    in   number_literal         value of var k+1 at bit k; snapshotted on start
//  assign_def    in   number_literal         1 = var k+1 assigned; snapshotted on start
//  busy          out  1                      high from cycle after accepted start until done
//  done          out  1                      one-cycle pulse; results valid from then until next accepted start
//  status        out  2                      00 UNRESOLVED, 01 SAT, 10 CONFLICT
//  conflict_idx  out  width_clausearray+1    index of first conflicting clause
//  unit_found    out  1                      a unit clause was seen
//  unit_num      out  width_litarray+1       literal number (1-based) of the unit literal
//  unit_val      out  1                      polarity of the unit literal (1 = positive)
// BEHAVIOUR
//  Reset: all outputs 0; FSM to IDLE; iterators and snapshots cleared. Reset mid-scan aborts with no done.
//  FSM: IDLE -> SCAN -> CLOSE -> (SCAN | DONE) -> IDLE.
//   IDLE: start=1 snapshots inputs and clears results.
//         If formula_in.len==0, go to DONE; else go to SCAN with clause 0.
//   SCAN: one literal per cycle, index 0..clauses[c].len-1. Literal l is classified:
//         true if assign_def[num-1] && assign_val[num-1]==val;
//         unassigned if !assign_def[num-1]; false otherwise.
//         num==0 or num>number_literal: ignored (neither true nor unassigned).
//         Tracks the true flag, unassigned count saturating at 2, and the last unassigned literal.
//         Clause with len==0 skips SCAN and goes straight to CLOSE (counts as satisfied).
//   CLOSE: one cycle per clause.
//         satisfied = true flag or len==0.
//         conflict  = !sat and unassigned==0.
//         unit      = !sat and unassigned==1.
//         First conflict latches conflict_idx. First unit latches unit_found/num/val; later units are ignored.
//         Next state: DONE if conflict and STOP_ON_CONFLICT, or if c==formula.len-1; else SCAN(c+1).
//   DONE: done=1 for exactly one cycle; busy drops the same cycle; return to IDLE.
//  status: CONFLICT if any conflict seen; else SAT if every evaluated clause satisfied; else UNRESOLVED.
//   unit_* remain reported even when status is CONFLICT.
//  Latency: done high N cycles after the start edge, N = sum over evaluated clauses of (len_k+1), plus 1.
//  start while busy, or in the DONE cycle, is ignored (no queuing).
//  Results and outputs hold stable in IDLE. Input changes after the snapshot have no effect.
// TESTING
//  T1 (x1|~x2)(x3), def=111, val=101 -> status=01 SAT, unit_found=0, done at cycle 6.
//  T2 (x1)(~x1)(x2), STOP_ON_CONFLICT=1, x1=1 -> CONFLICT, conflict_idx=1, done at cycle 5.
//     Same stimulus with STOP_ON_CONFLICT=0 -> same idx, done at cycle 7.
//  T3 (x1|x2), x1 def=0, x2 undef -> UNRESOLVED, unit_found=1, unit_num=2, unit_val=1.
//  T4 formula.len=0 -> SAT, done at cycle 1.
//     Clause with len 0 inside the formula is treated as satisfied and costs 1 cycle.
//  T5 start pulsed again at cycle 2 of T1 -> ignored, single done at cycle 6.
//     reset at cycle 3 -> busy=0, no done, all outputs 0.
//  T6 literal num=0 in clause (x0|x2), x2 def=0 -> CONFLICT (invalid literal ignored).

Source files
------------

// File: rtl/formula_evaluator_if.sv
// formula_evaluator_if: start/done handshake and result bundle
// between the DPLL search controller and the formula evaluator.
interface formula_evaluator_if #(
    parameter int clause_bits = 2,
    parameter int lit_bits = 3
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [1:0]           status;
    logic [clause_bits:0] conflict_idx;
    logic                 unit_found;
    logic [lit_bits:0]    unit_num;
    logic                 unit_val;

    modport master (
        output start,
        input  busy, done, status, conflict_idx,
        input  unit_found, unit_num, unit_val
    );

    modport slave (
        input  start,
        output busy, done, status, conflict_idx,
        output unit_found, unit_num, unit_val
    );
endinterface

// File: rtl/formula_evaluator.sv
// formula_evaluator: clause-by-clause CNF evaluation, one literal per
// cycle, reporting SAT/CONFLICT/UNRESOLVED and the first unit clause.
package formula_pkg;
    localparam int number_literal = 8;
    localparam int number_clauses = 4;
    localparam int width_litarray = $clog2(number_literal);
    localparam int width_clausearray = $clog2(number_clauses);

    typedef logic [width_litarray:0] lidx_t;
    typedef logic [width_clausearray:0] cidx_t;

    localparam lidx_t LIT_MAX = lidx_t'(number_literal);
    localparam cidx_t CLAUSE_MAX = cidx_t'(number_clauses);

    localparam logic [1:0] ST_UNRES = 2'b00;
    localparam logic [1:0] ST_SAT = 2'b01;
    localparam logic [1:0] ST_CONFLICT = 2'b10;

    typedef struct packed {
        logic  val;
        lidx_t num;
    } literal_t;

    typedef struct packed {
        lidx_t                          len;
        literal_t [number_literal-1:0] lits;
    } clause_t;

    typedef struct packed {
        cidx_t                         len;
        clause_t [number_clauses-1:0] clauses;
    } formula;

    // Over-long lengths are clamped to the storage the struct provides.
    function automatic lidx_t clause_len(input clause_t c);
        return (c.len > LIT_MAX) ? LIT_MAX : c.len;
    endfunction

    function automatic cidx_t clause_count(input formula f);
        return (f.len > CLAUSE_MAX) ? CLAUSE_MAX : f.len;
    endfunction
endpackage

module formula_evaluator
    import formula_pkg::*;
#(
    parameter bit STOP_ON_CONFLICT = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  formula                    formula_in,
    input  logic [number_literal-1:0] assign_val,
    input  logic [number_literal-1:0] assign_def,
    formula_evaluator_if.slave        eval
);
    typedef enum logic [1:0] {IDLE, SCAN, CLOSE, DONE} state_t;

    state_t                    state;
    formula                    f;
    logic [number_literal-1:0] val_q;
    logic [number_literal-1:0] def_q;
    cidx_t                     ci;
    lidx_t                     li;

    logic                      tflag;
    logic [1:0]                ucnt;
    literal_t                  ulast;
    logic                      conf_seen;
    logic                      all_sat;
    logic                      unit_seen;
    cidx_t                     conf_idx;
    literal_t                  unit_lit;

    logic                      busy_q;
    logic                      done_q;
    logic [1:0]                status_q;
    cidx_t                     conflict_q;
    logic                      unit_found_q;
    lidx_t                     unit_num_q;
    logic                      unit_val_q;

    clause_t                   cur_c;
    clause_t                   next_c;
    literal_t                  lit;
    lidx_t                     cur_len;
    lidx_t                     next_len;
    lidx_t                     nm1;
    cidx_t                     nci;
    cidx_t                     last_c;
    logic                      lit_ok;
    logic                      lit_true;
    logic                      lit_un;
    logic                      sat;
    logic                      conflict;
    logic                      unit;

    assign cur_c = f.clauses[ci[width_clausearray-1:0]];
    assign nci = ci + cidx_t'(1);
    assign next_c = f.clauses[nci[width_clausearray-1:0]];
    assign cur_len = clause_len(cur_c);
    assign next_len = clause_len(next_c);
    assign last_c = clause_count(f) - cidx_t'(1);

    // Literal numbers are 1-based; 0 and out-of-range numbers never count.
    assign lit = cur_c.lits[li[width_litarray-1:0]];
    assign lit_ok = (lit.num != '0) && (lit.num <= LIT_MAX);
    assign nm1 = lit.num - lidx_t'(1);
    assign lit_true = lit_ok && def_q[nm1[width_litarray-1:0]]
                      && (val_q[nm1[width_litarray-1:0]] == lit.val);
    assign lit_un = lit_ok && !def_q[nm1[width_litarray-1:0]];

    assign sat = tflag || (cur_len == '0);
    assign conflict = !sat && (ucnt == 2'd0);
    assign unit = !sat && (ucnt == 2'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            f            <= '0;
            val_q        <= '0;
            def_q        <= '0;
            ci           <= '0;
            li           <= '0;
            tflag        <= 1'b0;
            ucnt         <= 2'd0;
            ulast        <= '0;
            conf_seen    <= 1'b0;
            all_sat      <= 1'b0;
            unit_seen    <= 1'b0;
            conf_idx     <= '0;
            unit_lit     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= ST_UNRES;
            conflict_q   <= '0;
            unit_found_q <= 1'b0;
            unit_num_q   <= '0;
            unit_val_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    // The done cycle itself is still closing out: no restart.
                    if (eval.start && !done_q) begin
                        f            <= formula_in;
                        val_q        <= assign_val;
                        def_q        <= assign_def;
                        ci           <= '0;
                        li           <= '0;
                        tflag        <= 1'b0;
                        ucnt         <= 2'd0;
                        ulast        <= '0;
                        conf_seen    <= 1'b0;
                        all_sat      <= 1'b1;
                        unit_seen    <= 1'b0;
                        conf_idx     <= '0;
                        unit_lit     <= '0;
                        busy_q       <= 1'b1;
                        status_q     <= ST_UNRES;
                        conflict_q   <= '0;
                        unit_found_q <= 1'b0;
                        unit_num_q   <= '0;
                        unit_val_q   <= 1'b0;
                        if (formula_in.len == '0)
                            state <= DONE;
                        else if (clause_len(formula_in.clauses[0]) == '0)
                            state <= CLOSE;
                        else
                            state <= SCAN;
                    end
                end
                SCAN: begin
                    if (lit_true)
                        tflag <= 1'b1;
                    if (lit_un) begin
                        if (ucnt != 2'd2)
                            ucnt <= ucnt + 2'd1;
                        ulast <= lit;
                    end
                    if (li == cur_len - lidx_t'(1))
                        state <= CLOSE;
                    else
                        li <= li + lidx_t'(1);
                end
                CLOSE: begin
                    if (!sat)
                        all_sat <= 1'b0;
                    if (conflict && !conf_seen) begin
                        conf_seen <= 1'b1;
                        conf_idx  <= ci;
                    end
                    if (unit && !unit_seen) begin
                        unit_seen <= 1'b1;
                        unit_lit  <= ulast;
                    end
                    tflag <= 1'b0;
                    ucnt  <= 2'd0;
                    li    <= '0;
                    if ((conflict && STOP_ON_CONFLICT) || ci == last_c) begin
                        state <= DONE;
                    end else begin
                        ci    <= nci;
                        state <= (next_len == '0) ? CLOSE : SCAN;
                    end
                end
                DONE: begin
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    conflict_q   <= conf_idx;
                    unit_found_q <= unit_seen;
                    unit_num_q   <= unit_lit.num;
                    unit_val_q   <= unit_lit.val;
                    if (conf_seen)
                        status_q <= ST_CONFLICT;
                    else if (all_sat)
                        status_q <= ST_SAT;
                    else
                        status_q <= ST_UNRES;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign eval.busy         = busy_q;
    assign eval.done         = done_q;
    assign eval.status       = status_q;
    assign eval.conflict_idx = conflict_q;
    assign eval.unit_found   = unit_found_q;
    assign eval.unit_num     = unit_num_q;
    assign eval.unit_val     = unit_val_q;
endmodule

// File: tb/tb_formula_evaluator.sv
// tb_formula_evaluator: directed and randomized checks of both
// stop-on-conflict variants against a clause-level reference model.
module tb_formula_evaluator;
    import formula_pkg::*;

    typedef logic [number_literal-1:0] vec_t;

    logic   clock = 1'b0;
    logic   reset;
    logic   start;
    formula formula_in;
    vec_t   assign_val;
    vec_t   assign_def;

    int tests = 0;
    int fails = 0;

    logic [1:0] o_st[2];
    cidx_t      o_idx[2];
    logic       o_uf[2];
    lidx_t      o_un[2];
    logic       o_uv[2];
    int         o_lat[2];
    logic       o_done_after[2];

    formula_evaluator_if #(
        .clause_bits(width_clausearray),
        .lit_bits(width_litarray)
    ) ev_stop ();

    formula_evaluator_if #(
        .clause_bits(width_clausearray),
        .lit_bits(width_litarray)
    ) ev_all ();

    assign ev_stop.start = start;
    assign ev_all.start = start;

    formula_evaluator #(.STOP_ON_CONFLICT(1'b1)) dut_stop (
        .clock(clock),
        .reset(reset),
        .formula_in(formula_in),
        .assign_val(assign_val),
        .assign_def(assign_def),
        .eval(ev_stop)
    );

    formula_evaluator #(.STOP_ON_CONFLICT(1'b0)) dut_all (
        .clock(clock),
        .reset(reset),
        .formula_in(formula_in),
        .assign_val(assign_val),
        .assign_def(assign_def),
        .eval(ev_all)
    );

    always #5 clock = ~clock;

    function automatic literal_t mk(input logic v, input int n);
        literal_t l;
        l.val = v;
        l.num = lidx_t'(n);
        return l;
    endfunction

    function automatic formula mk_t1();
        formula r;
        r = '0;
        r.len = cidx_t'(2);
        r.clauses[0].len = lidx_t'(2);
        r.clauses[0].lits[0] = mk(1'b1, 1);
        r.clauses[0].lits[1] = mk(1'b0, 2);
        r.clauses[1].len = lidx_t'(1);
        r.clauses[1].lits[0] = mk(1'b1, 3);
        return r;
    endfunction

    function automatic formula mk_t2();
        formula r;
        r = '0;
        r.len = cidx_t'(3);
        r.clauses[0].len = lidx_t'(1);
        r.clauses[0].lits[0] = mk(1'b1, 1);
        r.clauses[1].len = lidx_t'(1);
        r.clauses[1].lits[0] = mk(1'b0, 1);
        r.clauses[2].len = lidx_t'(1);
        r.clauses[2].lits[0] = mk(1'b1, 2);
        return r;
    endfunction

    function automatic formula rand_formula();
        formula r;
        r = '0;
        r.len = cidx_t'($urandom_range(0, number_clauses));
        for (int c = 0; c < number_clauses; c++) begin
            if ($urandom_range(0, 3) == 0)
                r.clauses[c].len = lidx_t'($urandom_range(0, number_literal));
            else
                r.clauses[c].len = lidx_t'($urandom_range(0, 3));
            for (int k = 0; k < number_literal; k++) begin
                r.clauses[c].lits[k].val = 1'($urandom);
                r.clauses[c].lits[k].num =
                    lidx_t'($urandom_range(0, number_literal + 1));
            end
        end
        return r;
    endfunction

    // Clause-level semantics: walk clauses, classify literals, stop early
    // on a conflict only when asked to.
    task automatic model(
        input formula f, input vec_t v, input vec_t d, input bit stop,
        output logic [1:0] st, output cidx_t idx, output logic uf,
        output lidx_t un, output logic uv, output int lat
    );
        int nc;
        bit conf;
        bit allsat;
        nc = (int'(f.len) > number_clauses) ? number_clauses : int'(f.len);
        conf = 0;
        allsat = 1;
        idx = '0;
        uf = 1'b0;
        un = '0;
        uv = 1'b0;
        lat = 1;
        for (int c = 0; c < nc; c++) begin
            int len;
            int nun;
            int lastn;
            bit lastv;
            bit sat;
            len = int'(f.clauses[c].len);
            if (len > number_literal)
                len = number_literal;
            lat += len + 1;
            sat = (len == 0);
            nun = 0;
            lastn = 0;
            lastv = 0;
            for (int k = 0; k < len; k++) begin
                int n;
                bit pol;
                n = int'(f.clauses[c].lits[k].num);
                pol = f.clauses[c].lits[k].val;
                if (n >= 1 && n <= number_literal) begin
                    if (d[n-1]) begin
                        if (v[n-1] == pol)
                            sat = 1;
                    end else begin
                        nun++;
                        lastn = n;
                        lastv = pol;
                    end
                end
            end
            if (!sat) begin
                allsat = 0;
                if (nun == 0) begin
                    if (!conf) begin
                        conf = 1;
                        idx = cidx_t'(c);
                    end
                    if (stop)
                        break;
                end else if (nun == 1 && !uf) begin
                    uf = 1'b1;
                    un = lidx_t'(lastn);
                    uv = lastv;
                end
            end
        end
        st = conf ? 2'b10 : (allsat ? 2'b01 : 2'b00);
    endtask

    task automatic run_eval(input formula f, input vec_t v, input vec_t d);
        formula_in = f;
        assign_val = v;
        assign_def = d;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        formula_in = rand_formula();
        assign_val = vec_t'($urandom);
        assign_def = vec_t'($urandom);
        o_lat[0] = -1;
        o_lat[1] = -1;
        o_done_after[0] = 1'bx;
        o_done_after[1] = 1'bx;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clock);
            #1;
            if (o_lat[0] == cyc - 1)
                o_done_after[0] = ev_stop.done;
            if (o_lat[1] == cyc - 1)
                o_done_after[1] = ev_all.done;
            if (ev_stop.done && o_lat[0] < 0) begin
                o_lat[0] = cyc;
                o_st[0] = ev_stop.status;
                o_idx[0] = ev_stop.conflict_idx;
                o_uf[0] = ev_stop.unit_found;
                o_un[0] = ev_stop.unit_num;
                o_uv[0] = ev_stop.unit_val;
            end
            if (ev_all.done && o_lat[1] < 0) begin
                o_lat[1] = cyc;
                o_st[1] = ev_all.status;
                o_idx[1] = ev_all.conflict_idx;
                o_uf[1] = ev_all.unit_found;
                o_un[1] = ev_all.unit_num;
                o_uv[1] = ev_all.unit_val;
            end
            if (o_lat[0] >= 0 && o_lat[1] >= 0
                && cyc > o_lat[0] && cyc > o_lat[1])
                break;
        end
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (o_lat[k] < 0) begin
                fails++;
                $display("FAIL done_timeout dut%0d: no done within 200 cycles", k);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        formula_in = '0;
        assign_val = '0;
        assign_def = '0;
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if ({ev_stop.busy, ev_stop.done, ev_stop.status, ev_stop.conflict_idx,
             ev_stop.unit_found, ev_stop.unit_num, ev_stop.unit_val} !== '0) begin
            fails++;
            $display("FAIL reset_outputs_stop: got %b want 0",
                     {ev_stop.busy, ev_stop.done, ev_stop.status});
        end
        tests++;
        if ({ev_all.busy, ev_all.done, ev_all.status, ev_all.conflict_idx,
             ev_all.unit_found, ev_all.unit_num, ev_all.unit_val} !== '0) begin
            fails++;
            $display("FAIL reset_outputs_all: got %b want 0",
                     {ev_all.busy, ev_all.done, ev_all.status});
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_sat();
        run_eval(mk_t1(), vec_t'(8'b101), vec_t'(8'b111));
        tests++;
        if (o_st[0] !== 2'b01) begin
            fails++;
            $display("FAIL t1_status: got %0d want 1", o_st[0]);
        end
        tests++;
        if (o_uf[0] !== 1'b0) begin
            fails++;
            $display("FAIL t1_unit_found: got %0d want 0", o_uf[0]);
        end
        tests++;
        if (o_lat[0] != 6) begin
            fails++;
            $display("FAIL t1_latency: got %0d want 6", o_lat[0]);
        end
        tests++;
        if (o_done_after[0] !== 1'b0) begin
            fails++;
            $display("FAIL t1_done_pulse: got %0d want 0", o_done_after[0]);
        end
    endtask

    task automatic test_conflict();
        run_eval(mk_t2(), vec_t'(8'b011), vec_t'(8'b011));
        tests++;
        if (o_st[0] !== 2'b10 || o_idx[0] !== cidx_t'(1)) begin
            fails++;
            $display("FAIL t2_stop_result: got st=%0d idx=%0d want st=2 idx=1",
                     o_st[0], o_idx[0]);
        end
        tests++;
        if (o_lat[0] != 5) begin
            fails++;
            $display("FAIL t2_stop_latency: got %0d want 5", o_lat[0]);
        end
        tests++;
        if (o_st[1] !== 2'b10 || o_idx[1] !== cidx_t'(1)) begin
            fails++;
            $display("FAIL t2_all_result: got st=%0d idx=%0d want st=2 idx=1",
                     o_st[1], o_idx[1]);
        end
        tests++;
        if (o_lat[1] != 7) begin
            fails++;
            $display("FAIL t2_all_latency: got %0d want 7", o_lat[1]);
        end
    endtask

    task automatic test_unit();
        formula f;
        f = '0;
        f.len = cidx_t'(1);
        f.clauses[0].len = lidx_t'(2);
        f.clauses[0].lits[0] = mk(1'b1, 1);
        f.clauses[0].lits[1] = mk(1'b1, 2);
        run_eval(f, vec_t'(8'b000), vec_t'(8'b001));
        tests++;
        if (o_st[0] !== 2'b00) begin
            fails++;
            $display("FAIL t3_status: got %0d want 0", o_st[0]);
        end
        tests++;
        if (o_uf[0] !== 1'b1 || o_un[0] !== lidx_t'(2) || o_uv[0] !== 1'b1) begin
            fails++;
            $display("FAIL t3_unit: got f=%0d n=%0d v=%0d want f=1 n=2 v=1",
                     o_uf[0], o_un[0], o_uv[0]);
        end
        tests++;
        if (o_lat[0] != 4) begin
            fails++;
            $display("FAIL t3_latency: got %0d want 4", o_lat[0]);
        end
    endtask

    task automatic test_empty();
        formula f;
        f = mk_t1();
        f.len = '0;
        run_eval(f, vec_t'(8'b000), vec_t'(8'b000));
        tests++;
        if (o_st[0] !== 2'b01 || o_lat[0] != 1) begin
            fails++;
            $display("FAIL t4_empty_formula: got st=%0d lat=%0d want st=1 lat=1",
                     o_st[0], o_lat[0]);
        end
        f = '0;
        f.len = cidx_t'(2);
        f.clauses[0].len = lidx_t'(1);
        f.clauses[0].lits[0] = mk(1'b1, 1);
        f.clauses[1].len = '0;
        run_eval(f, vec_t'(8'b001), vec_t'(8'b001));
        tests++;
        if (o_st[0] !== 2'b01 || o_lat[0] != 4) begin
            fails++;
            $display("FAIL t4_empty_clause: got st=%0d lat=%0d want st=1 lat=4",
                     o_st[0], o_lat[0]);
        end
    endtask

    task automatic test_invalid_literal();
        formula f;
        f = '0;
        f.len = cidx_t'(1);
        f.clauses[0].len = lidx_t'(2);
        f.clauses[0].lits[0] = mk(1'b1, 0);
        f.clauses[0].lits[1] = mk(1'b1, 2);
        run_eval(f, vec_t'(8'b000), vec_t'(8'b010));
        tests++;
        if (o_st[0] !== 2'b10 || o_idx[0] !== '0 || o_uf[0] !== 1'b0) begin
            fails++;
            $display("FAIL t6_invalid_lit: got st=%0d idx=%0d uf=%0d want 2 0 0",
                     o_st[0], o_idx[0], o_uf[0]);
        end
    endtask

    task automatic test_start_ignored();
        int ndone;
        int dcyc;
        int extra;
        logic [1:0] st;
        bit busy_bad;
        formula_in = mk_t1();
        assign_val = vec_t'(8'b101);
        assign_def = vec_t'(8'b111);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        ndone = 0;
        dcyc = -1;
        st = 2'b11;
        for (int cyc = 1; cyc <= 12 && dcyc < 0; cyc++) begin
            @(posedge clock);
            #1;
            if (cyc == 2) begin
                formula_in = mk_t2();
                assign_val = vec_t'(8'b011);
                assign_def = vec_t'(8'b011);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (ev_stop.done) begin
                ndone++;
                dcyc = cyc;
                st = ev_stop.status;
            end
        end
        start = 1'b1;
        @(posedge clock);
        #1;
        busy_bad = ev_stop.busy || ev_all.busy;
        start = 1'b0;
        extra = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (ev_stop.done)
                extra++;
        end
        tests++;
        if (dcyc != 6 || st !== 2'b01) begin
            fails++;
            $display("FAIL t5_restart_ignored: got cyc=%0d st=%0d want 6 1",
                     dcyc, st);
        end
        tests++;
        if (busy_bad || extra != 0) begin
            fails++;
            $display("FAIL t5_done_cycle_start: got busy=%0d extra=%0d want 0 0",
                     busy_bad, extra);
        end
    endtask

    task automatic test_reset_midscan();
        int seen;
        formula_in = mk_t1();
        assign_val = vec_t'(8'b101);
        assign_def = vec_t'(8'b111);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if (ev_stop.busy !== 1'b1) begin
            fails++;
            $display("FAIL t5_busy_midscan: got %0d want 1", ev_stop.busy);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tests++;
        if ({ev_stop.busy, ev_stop.done, ev_stop.status, ev_stop.conflict_idx,
             ev_stop.unit_found, ev_stop.unit_num, ev_stop.unit_val} !== '0) begin
            fails++;
            $display("FAIL t5_reset_midscan: got busy=%0d st=%0d want 0 0",
                     ev_stop.busy, ev_stop.status);
        end
        seen = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (ev_stop.done || ev_all.done)
                seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL t5_no_done_after_reset: got %0d want 0", seen);
        end
    endtask

    task automatic test_random();
        formula f;
        vec_t v;
        vec_t d;
        logic [1:0] m_st;
        cidx_t m_idx;
        logic m_uf;
        lidx_t m_un;
        logic m_uv;
        int m_lat;
        for (int it = 0; it < 40; it++) begin
            f = rand_formula();
            v = vec_t'($urandom);
            d = vec_t'($urandom | $urandom);
            run_eval(f, v, d);
            for (int k = 0; k < 2; k++) begin
                model(f, v, d, (k == 0), m_st, m_idx, m_uf, m_un, m_uv, m_lat);
                tests++;
                if (o_st[k] !== m_st || o_idx[k] !== m_idx) begin
                    fails++;
                    $display("FAIL rnd%0d_result dut%0d: got st=%0d idx=%0d want %0d %0d",
                             it, k, o_st[k], o_idx[k], m_st, m_idx);
                end
                tests++;
                if (o_uf[k] !== m_uf || o_un[k] !== m_un || o_uv[k] !== m_uv) begin
                    fails++;
                    $display("FAIL rnd%0d_unit dut%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                             it, k, o_uf[k], o_un[k], o_uv[k], m_uf, m_un, m_uv);
                end
                tests++;
                if (o_lat[k] != m_lat || o_done_after[k] !== 1'b0) begin
                    fails++;
                    $display("FAIL rnd%0d_timing dut%0d: got lat=%0d after=%0d want %0d 0",
                             it, k, o_lat[k], o_done_after[k], m_lat);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sat();
        test_conflict();
        test_unit();
        test_empty();
        test_invalid_literal();
        test_start_ignored();
        test_reset_midscan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
